// File: rtl/finalproject_pkg.sv
// Shared types and constants for the target game: FSM state encoding, LFSR seed,
// number of targets, and a helper that turns a target index into its LED pattern.
package finalproject_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GAP  = 2'd1,
        ST_LIT  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [15:0] LFSR_SEED   = 16'hACE1;
    localparam int unsigned NUM_TARGETS = 3;

    function automatic logic [NUM_TARGETS-1:0] target_onehot(input logic [1:0] idx);
        logic [NUM_TARGETS-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_TARGETS; i++) begin
            if (idx == i[1:0]) oh[i] = 1'b1;
        end
        return oh;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), shifting right with the
// feedback bit entering at the MSB.
module lfsr16
    import finalproject_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED
) (
    input  logic        clock,
    input  logic        reset,
    output logic [15:0] value
);

    logic feedback;

    assign feedback = value[0] ^ value[2] ^ value[3] ^ value[5];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) value <= SEED;
        else        value <= {feedback, value[15:1]};
    end

endmodule

// File: rtl/target_sequencer.sv
// Reaction-game sequencer: lights one of three targets per round, scores a hit on
// a synchronized rising edge of that target's sensor, or times out as a miss.
// Define TARGET_SEQ_LFSR_EN to pick targets from lfsr16 instead of round-robin.
module target_sequencer
    import finalproject_pkg::*;
#(
    parameter logic [31:0] LIT_CYCLES = 32'd50_000_000,
    parameter logic [31:0] GAP_CYCLES = 32'd25_000_000,
    parameter logic [7:0]  ROUNDS     = 8'd20
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [NUM_TARGETS-1:0] hit_in,
    output logic [NUM_TARGETS-1:0] target_led,
    output logic                   hit_pulse,
    output logic                   miss_pulse,
    output logic [7:0]             round_count,
    output logic                   busy,
    output logic                   done,
    output state_t                 state_dbg
);

    logic [NUM_TARGETS-1:0] sync1, sync2, sync3, edge_q;
    state_t                 state, state_n;
    logic [31:0]            timer, timer_n;
    logic [7:0]             round_q, round_n;
    logic [1:0]             tgt, tgt_n, next_idx;
    logic                   hit_n, miss_n, lit_hit, expired;

    // Edges are only captured while lit, so a rise that happened before LIT entry never scores.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1  <= '0;
            sync2  <= '0;
            sync3  <= '0;
            edge_q <= '0;
        end else begin
            sync1  <= hit_in;
            sync2  <= sync1;
            sync3  <= sync2;
            edge_q <= (state == ST_LIT) ? (sync2 & ~sync3) : '0;
        end
    end

`ifdef TARGET_SEQ_LFSR_EN
    logic [15:0] lfsr_value;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clock (clock),
        .reset (reset),
        .value (lfsr_value)
    );

    assign next_idx = (lfsr_value[1:0] == 2'd3) ? 2'd0 : lfsr_value[1:0];
`else
    assign next_idx = (tgt == 2'd2) ? 2'd0 : tgt + 2'd1;
`endif

    assign lit_hit = |(edge_q & target_onehot(tgt));
    assign expired = (timer == LIT_CYCLES - 32'd1);

    always_comb begin
        state_n = state;
        timer_n = timer;
        round_n = round_q;
        tgt_n   = tgt;
        hit_n   = 1'b0;
        miss_n  = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_n = ST_GAP;
                    timer_n = '0;
                    round_n = '0;
                    // Parked on the last target so round-robin picks target 0 first.
                    tgt_n   = 2'd2;
                end
            end
            ST_GAP: begin
                if (timer == GAP_CYCLES - 32'd1) begin
                    state_n = ST_LIT;
                    timer_n = '0;
                    tgt_n   = next_idx;
                end else begin
                    timer_n = timer + 32'd1;
                end
            end
            ST_LIT: begin
                if (lit_hit || expired) begin
                    hit_n   = lit_hit;
                    miss_n  = !lit_hit;
                    round_n = round_q + 8'd1;
                    timer_n = '0;
                    state_n = (round_q + 8'd1 == ROUNDS) ? ST_DONE : ST_GAP;
                end else begin
                    timer_n = timer + 32'd1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            timer      <= '0;
            round_q    <= '0;
            tgt        <= '0;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
        end else begin
            state      <= state_n;
            timer      <= timer_n;
            round_q    <= round_n;
            tgt        <= tgt_n;
            hit_pulse  <= hit_n;
            miss_pulse <= miss_n;
        end
    end

    assign target_led  = (state == ST_LIT) ? target_onehot(tgt) : '0;
    assign round_count = round_q;
    assign busy        = (state == ST_GAP) || (state == ST_LIT);
    assign done        = (state == ST_DONE);
    assign state_dbg   = state;

endmodule

// File: tb/tb_target_sequencer.sv
// Bench for target_sequencer with LIT_CYCLES=10, GAP_CYCLES=4, ROUNDS=3: directed
// table, hand-written corner sequences, and random stimulus against a game model.
module tb_target_sequencer;
    import finalproject_pkg::*;

    localparam int LIT = 10;
    localparam int GAP = 4;
    localparam int RND = 3;
    localparam int P_IDLE = 0, P_GAP = 1, P_LIT = 2, P_DONE = 3;

    logic       clock;
    logic       reset;
    logic       start;
    logic [2:0] hit_in;
    logic [2:0] target_led;
    logic       hit_pulse;
    logic       miss_pulse;
    logic [7:0] round_count;
    logic       busy;
    logic       done;
    state_t     state_dbg;

    int n_vec = 0;
    int n_bad = 0;

    target_sequencer #(
        .LIT_CYCLES (32'd10),
        .GAP_CYCLES (32'd4),
        .ROUNDS     (8'd3)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .hit_in      (hit_in),
        .target_led  (target_led),
        .hit_pulse   (hit_pulse),
        .miss_pulse  (miss_pulse),
        .round_count (round_count),
        .busy        (busy),
        .done        (done),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A game-level view: raw sensor samples kept as a short history; a rise of the
    // lit line sampled at edge j scores at edge j+3 if the target was lit across it.
    int          m_phase, m_cnt, m_round, m_tgt, m_next;
    bit          m_lit_prev, m_hit, m_miss;
    logic [2:0]  m_raw [5];
    logic [15:0] m_lfsr;

    task automatic model_step(input logic r, input logic s, input logic [2:0] h);
        bit          was_lit, scored;
        int          pick;
        logic [15:0] fb16;
        m_hit  = 0;
        m_miss = 0;
        if (!r) begin
            m_phase = P_IDLE; m_cnt = 0; m_round = 0; m_tgt = 0; m_next = 0;
            m_lit_prev = 0;
            for (int i = 0; i < 5; i++) m_raw[i] = 3'b000;
            m_lfsr = 16'hACE1;
            return;
        end
        was_lit = (m_phase == P_LIT);
        for (int i = 4; i > 0; i--) m_raw[i] = m_raw[i-1];
        m_raw[0] = h;
        scored = was_lit && m_lit_prev && m_raw[3][m_tgt] && !m_raw[4][m_tgt];
`ifdef TARGET_SEQ_LFSR_EN
        pick = int'(m_lfsr % 16'd4);
        if (pick == 3) pick = 0;
`else
        pick = m_next;
`endif
        case (m_phase)
            P_IDLE, P_DONE: if (s) begin
                m_phase = P_GAP; m_cnt = 0; m_round = 0; m_next = 0;
            end
            P_GAP: if (m_cnt == GAP - 1) begin
                m_phase = P_LIT; m_cnt = 0; m_tgt = pick; m_next = (pick + 1) % 3;
            end else m_cnt++;
            default: if (scored || m_cnt == LIT - 1) begin
                m_hit = scored; m_miss = !scored; m_round++; m_cnt = 0;
                m_phase = (m_round == RND) ? P_DONE : P_GAP;
            end else m_cnt++;
        endcase
        m_lit_prev = was_lit;
        fb16   = (m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 16'd1;
        m_lfsr = (m_lfsr >> 1) | (fb16 << 15);
    endtask

    always @(posedge clock) begin
        logic       r, s;
        logic [2:0] h;
        logic [2:0] el;
        r = reset; s = start; h = hit_in;
        #1;
        model_step(r, s, h);
        el = (m_phase == P_LIT) ? 3'(1 << m_tgt) : 3'b000;
        chk("model_outputs", {target_led, hit_pulse, miss_pulse, round_count, busy, done},
            {el, m_hit, m_miss, 8'(m_round), m_phase == P_GAP || m_phase == P_LIT, m_phase == P_DONE});
    end

    // ---------------- driver tasks ----------------
    typedef struct {
        logic       st;
        logic [2:0] hit;
        logic [2:0] led;
        logic       hp;
        logic       mp;
        logic [7:0] rc;
        logic       bz;
        logic       dn;
    } row_t;
    row_t tbl[$];

    function automatic void add_row(input logic st, input logic [2:0] hit, input logic [2:0] led,
                                    input logic hp, input logic mp, input logic [7:0] rc,
                                    input logic bz, input logic dn);
        row_t r;
        r.st = st; r.hit = hit; r.led = led; r.hp = hp; r.mp = mp; r.rc = rc; r.bz = bz; r.dn = dn;
        tbl.push_back(r);
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_lit(input string name);
        int n = 0;
        while (target_led == 3'b000 && n < 40) begin
            @(negedge clock);
            n++;
        end
        chk(name, 32'(target_led != 3'b000), 32'd1);
    endtask

    task automatic wait_round_end(input string name);
        int n = 0;
        while (!(hit_pulse || miss_pulse) && n < 40) begin
            @(negedge clock);
            n++;
        end
        chk(name, 32'(hit_pulse || miss_pulse), 32'd1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [2:0] lit;
        int         hp_cnt, ms_cnt;

        reset = 1'b0; start = 1'b0; hit_in = 3'b000;
        repeat (3) @(negedge clock);
        chk("reset_outputs", {target_led, hit_pulse, miss_pulse, round_count, busy, done}, 32'd0);
        reset = 1'b1;

`ifndef TARGET_SEQ_LFSR_EN
        add_row(0, 3'b000, 3'b000, 0, 0, 8'd0, 0, 0);
        add_row(1, 3'b000, 3'b000, 0, 0, 8'd0, 1, 0);
        repeat (3) add_row(0, 3'b000, 3'b000, 0, 0, 8'd0, 1, 0);
        add_row(0, 3'b000, 3'b001, 0, 0, 8'd0, 1, 0);
        repeat (3) add_row(0, 3'b001, 3'b001, 0, 0, 8'd0, 1, 0);
        add_row(0, 3'b001, 3'b000, 1, 0, 8'd1, 1, 0);
        repeat (3) add_row(0, 3'b000, 3'b000, 0, 0, 8'd1, 1, 0);
        add_row(0, 3'b000, 3'b010, 0, 0, 8'd1, 1, 0);
        for (int k = 0; k < 9; k++) add_row(k == 4, 3'b000, 3'b010, 0, 0, 8'd1, 1, 0);
        add_row(0, 3'b000, 3'b000, 0, 1, 8'd2, 1, 0);
        repeat (3) add_row(0, 3'b000, 3'b000, 0, 0, 8'd2, 1, 0);
        add_row(0, 3'b000, 3'b100, 0, 0, 8'd2, 1, 0);
        repeat (9) add_row(0, 3'b000, 3'b100, 0, 0, 8'd2, 1, 0);
        add_row(0, 3'b000, 3'b000, 0, 1, 8'd3, 0, 1);
        add_row(0, 3'b000, 3'b000, 0, 0, 8'd3, 0, 1);
        add_row(1, 3'b000, 3'b000, 0, 0, 8'd0, 1, 0);
        repeat (3) add_row(0, 3'b000, 3'b000, 0, 0, 8'd0, 1, 0);
        add_row(0, 3'b000, 3'b001, 0, 0, 8'd0, 1, 0);
        for (int i = 0; i < tbl.size(); i++) begin
            start  = tbl[i].st;
            hit_in = tbl[i].hit;
            @(negedge clock);
            chk($sformatf("tbl_row%0d", i),
                {target_led, hit_pulse, miss_pulse, round_count, busy, done},
                {tbl[i].led, tbl[i].hp, tbl[i].mp, tbl[i].rc, tbl[i].bz, tbl[i].dn});
        end
        start = 1'b0; hit_in = 3'b000;
`else
        pulse_start();
        wait_lit("lit_first");
`endif

        // Round 1 of this game times out; then a level held across GAP into LIT.
        wait_round_end("first_timeout");
        hit_in = 3'b111;
        wait_lit("lit_held");
        lit = target_led;
        hp_cnt = 0; ms_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            hit_in = lit | ((k % 2 == 1) ? (~lit & 3'b111) : 3'b000);
            @(negedge clock);
            if (hit_pulse) hp_cnt++;
            if (miss_pulse) begin
                ms_cnt++;
                break;
            end
        end
        chk("held_no_hit", 32'(hp_cnt), 32'd0);
        chk("held_miss", 32'(ms_cnt), 32'd1);
        hit_in = 3'b000;

        // Hit edge lands on the same edge as the lit timer expiry.
        wait_lit("lit_coincide");
        repeat (6) @(negedge clock);
        hit_in = target_led;
        repeat (4) @(negedge clock);
        chk("coincide_hit", 32'(hit_pulse), 32'd1);
        chk("coincide_miss", 32'(miss_pulse), 32'd0);
        chk("coincide_done", 32'(done), 32'd1);
        chk("coincide_rc", 32'(round_count), 32'd3);
        hit_in = 3'b000;

        // Reset mid-LIT with a hit edge in flight.
        pulse_start();
        wait_lit("lit_rst1");
        wait_round_end("rst_round1_end");
        wait_lit("lit_rst2");
        repeat (3) @(negedge clock);
        hit_in = target_led;
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rst_led", 32'(target_led), 32'd0);
        chk("rst_hit", 32'(hit_pulse), 32'd0);
        chk("rst_miss", 32'(miss_pulse), 32'd0);
        chk("rst_rc", 32'(round_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        hit_in = 3'b000;
        repeat (12) @(negedge clock);
        chk("idle_after_rst_busy", 32'(busy), 32'd0);
        chk("idle_after_rst_rc", 32'(round_count), 32'd0);

        // Random starts and sensor activity, checked cycle by cycle by the model.
        for (int c = 0; c < 700; c++) begin
            start = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) hit_in = 3'($urandom_range(0, 7));
            @(negedge clock);
        end
        start = 1'b0; hit_in = 3'b000;
        repeat (5) @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
